// File: rtl/microcode_sequencer_if.sv
// ============================================================================
// Module      : microcode_sequencer_if
// Description : Bundle of the sequencer's control, program-ROM and datapath
//               signals. Names are seen from the sequencer side: i_* are
//               driven into the sequencer, o_* are driven by it.
//                 i_start / i_start_addr      : run request and entry point
//                 o_busy / o_done             : run status, done is a pulse
//                 o_rom_addr / i_rom_q        : synchronous program ROM port
//                 o_ram_a_addr / o_ram_b_addr : operand / result addresses
//                 o_ram_b_w                   : RAM B write enable
//                 o_pe_op / o_pe_load / o_pe_en : processing-element control
//               master = sequencer, slave = surrounding system / bench.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface microcode_sequencer_if #(
   parameter int AW     = 6,
   parameter int ROM_AW = 9,
   parameter int TW     = 6
);
   localparam int IW = 3*AW + 3 + TW;

   logic              i_start;
   logic [ROM_AW-1:0] i_start_addr;
   logic              o_busy;
   logic              o_done;
   logic [ROM_AW-1:0] o_rom_addr;
   logic [IW-1:0]     i_rom_q;
   logic [AW-1:0]     o_ram_a_addr;
   logic [AW-1:0]     o_ram_b_addr;
   logic              o_ram_b_w;
   logic [2:0]        o_pe_op;
   logic              o_pe_load;
   logic              o_pe_en;

   modport master (
      input  i_start, i_start_addr, i_rom_q,
      output o_busy, o_done, o_rom_addr, o_ram_a_addr, o_ram_b_addr,
             o_ram_b_w, o_pe_op, o_pe_load, o_pe_en
   );

   modport slave (
      output i_start, i_start_addr, i_rom_q,
      input  o_busy, o_done, o_rom_addr, o_ram_a_addr, o_ram_b_addr,
             o_ram_b_w, o_pe_op, o_pe_load, o_pe_en
   );
endinterface

`default_nettype wire

// File: rtl/microcode_sequencer.sv
// ============================================================================
// Module      : microcode_sequencer
// Description : Microcode sequencer for the tower-field arithmetic datapath.
//               Fetches instructions {dest, src1, op, times, src2} from a
//               1-cycle-latency program ROM, drives RAM A/B addresses and PE
//               strobes, supports NOP, HALT and a single-level hardware LOOP.
// Ports       : clk   - clock, all state on rising edge
//               rst_n - asynchronous active-low reset (holds IDLE)
//               bus   - microcode_sequencer_if.master (start/busy/done,
//                       ROM port, RAM addresses, PE controls)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module microcode_sequencer #(
   parameter int AW     = 6,
   parameter int ROM_AW = 9,
   parameter int TW     = 6
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   microcode_sequencer_if.master bus
);
   localparam int IW = 3*AW + 3 + TW;

   localparam logic [2:0] c_OP_LOOP = 3'd4;
   localparam logic [2:0] c_OP_HALT = 3'd5;
   localparam logic [2:0] c_OP_NOP0 = 3'd6;
   localparam logic [2:0] c_OP_NOP1 = 3'd7;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_LOAD   = 3'd3,
      S_RUN    = 3'd4,
      S_WB     = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   state_t            r_state;
   logic [IW-1:0]     r_ir;
   logic [ROM_AW-1:0] r_rom_addr;
   logic [TW-1:0]     r_run_cnt;
   logic [TW-1:0]     r_loop_cnt;
   logic              r_loop_active;
   logic              r_busy;
   logic              r_done;
   logic              r_pe_load;
   logic              r_pe_en;
   logic              r_ram_b_w;

   // Fields of the word arriving from the ROM (decoded in DECODE)
   logic [2:0]        w_q_op;
   logic [TW-1:0]     w_q_times;
   logic [AW-1:0]     w_q_src1;
   logic [AW-1:0]     w_q_src2;
   // Fields of the latched instruction (used in LOAD/RUN/WB)
   logic [AW-1:0]     w_ir_dest;
   logic [AW-1:0]     w_ir_src1;
   logic [AW-1:0]     w_ir_src2;
   logic [2:0]        w_ir_op;
   logic [TW-1:0]     w_ir_times;
   logic [ROM_AW-1:0] w_loop_target;
   logic [ROM_AW-1:0] w_rom_next;

   assign w_q_src2   = bus.i_rom_q[AW-1:0];
   assign w_q_times  = bus.i_rom_q[AW+TW-1:AW];
   assign w_q_op     = bus.i_rom_q[AW+TW+2:AW+TW];
   assign w_q_src1   = bus.i_rom_q[2*AW+TW+2:AW+TW+3];

   assign w_ir_src2  = r_ir[AW-1:0];
   assign w_ir_times = r_ir[AW+TW-1:AW];
   assign w_ir_op    = r_ir[AW+TW+2:AW+TW];
   assign w_ir_src1  = r_ir[2*AW+TW+2:AW+TW+3];
   assign w_ir_dest  = r_ir[3*AW+TW+2:2*AW+TW+3];

   // Jump target is {src1,src2} resized to the ROM address width
   assign w_loop_target = ROM_AW'({w_q_src1, w_q_src2});
   // Sequential next address, wraps silently at the top of the ROM
   assign w_rom_next    = r_rom_addr + ROM_AW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_ir          <= '0;
         r_rom_addr    <= '0;
         r_run_cnt     <= '0;
         r_loop_cnt    <= '0;
         r_loop_active <= 1'b0;
         r_busy        <= 1'b0;
         r_done        <= 1'b0;
         r_pe_load     <= 1'b0;
         r_pe_en       <= 1'b0;
         r_ram_b_w     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_loop_active <= 1'b0;
               if (bus.i_start) begin
                  r_rom_addr <= bus.i_start_addr;
                  r_busy     <= 1'b1;
                  r_state    <= S_FETCH;
               end
            end
            S_FETCH: begin
               r_state <= S_DECODE;
            end
            S_DECODE: begin
               r_ir <= bus.i_rom_q;
               case (w_q_op)
                  c_OP_HALT: begin
                     r_loop_active <= 1'b0;
                     r_done        <= 1'b1;
                     r_state       <= S_DONE;
                  end
                  c_OP_LOOP: begin
                     r_state <= S_FETCH;
                     if (!r_loop_active) begin
                        if (w_q_times == '0) begin
                           r_rom_addr <= w_rom_next;
                        end else begin
                           // First pass already ran, so times-1 jumps remain
                           r_loop_cnt    <= w_q_times - TW'(1);
                           r_loop_active <= 1'b1;
                           r_rom_addr    <= w_loop_target;
                        end
                     end else if (r_loop_cnt != '0) begin
                        r_loop_cnt <= r_loop_cnt - TW'(1);
                        r_rom_addr <= w_loop_target;
                     end else begin
                        r_loop_active <= 1'b0;
                        r_rom_addr    <= w_rom_next;
                     end
                  end
                  c_OP_NOP0, c_OP_NOP1: begin
                     r_rom_addr <= w_rom_next;
                     r_state    <= S_FETCH;
                  end
                  default: begin
                     r_pe_load <= 1'b1;
                     r_state   <= S_LOAD;
                  end
               endcase
            end
            S_LOAD: begin
               // times = 0 still gives one PE step
               r_run_cnt <= (w_ir_times == '0) ? TW'(1) : w_ir_times;
               r_pe_load <= 1'b0;
               r_pe_en   <= 1'b1;
               r_state   <= S_RUN;
            end
            S_RUN: begin
               if (r_run_cnt <= TW'(1)) begin
                  r_pe_en   <= 1'b0;
                  r_ram_b_w <= 1'b1;
                  r_state   <= S_WB;
               end else begin
                  r_run_cnt <= r_run_cnt - TW'(1);
               end
            end
            S_WB: begin
               r_ram_b_w  <= 1'b0;
               r_rom_addr <= w_rom_next;
               r_state    <= S_FETCH;
            end
            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Strobes come straight from registers; address/opcode fields are a
   // decode of the registered state and instruction register.
   assign bus.o_busy       = r_busy;
   assign bus.o_done       = r_done;
   assign bus.o_rom_addr   = r_rom_addr;
   assign bus.o_pe_load    = r_pe_load;
   assign bus.o_pe_en      = r_pe_en;
   assign bus.o_ram_b_w    = r_ram_b_w;
   assign bus.o_ram_a_addr = (r_state == S_LOAD) ? w_ir_src1 : '0;
   assign bus.o_ram_b_addr = (r_state == S_LOAD) ? w_ir_src2 :
                             (r_state == S_WB)   ? w_ir_dest : '0;
   assign bus.o_pe_op      = (r_state == S_LOAD || r_state == S_RUN) ? w_ir_op : 3'd0;

endmodule

`default_nettype wire
